// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: write-pointer synchronizer, read pointers,
// RAM read issue and a 2-entry first-word-fall-through output buffer.
module async_fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_level
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         sync_d [SYNC_STAGES];
  logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
  logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;

  logic [PW-1:0]         wq_ptr_gray;
  logic [PW-1:0]         wq_ptr_bin;
  logic [PW-1:0]         rd_ptr_bin_nxt;
  logic                  ram_empty;
  logic                  pop;
  logic                  ren;
  logic [2:0]            credit;

  always_comb begin
    sync_d[0] = wr_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    wq_ptr_gray        = sync_q[SYNC_STAGES-1];
    wq_ptr_bin         = '0;
    wq_ptr_bin[PW-1]   = wq_ptr_gray[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wq_ptr_bin[i] = wq_ptr_bin[i+1] ^ wq_ptr_gray[i];
    end
  end

  // Words already buffered or on their way back must leave room for the one being issued.
  always_comb begin
    ram_empty      = (rd_ptr_gray_q == wq_ptr_gray);
    pop            = (occ_q != 2'd0) & dout_ready;
    credit         = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    ren            = !rst & !ram_empty & (credit < 3'd2);
    rd_ptr_bin_nxt = rd_ptr_bin_q + {{(PW-1){1'b0}}, 1'b1};
    rd_ptr_bin_d   = rd_ptr_bin_q;
    rd_ptr_gray_d  = rd_ptr_gray_q;
    if (ren) begin
      rd_ptr_bin_d  = rd_ptr_bin_nxt;
      rd_ptr_gray_d = rd_ptr_bin_nxt ^ (rd_ptr_bin_nxt >> 1);
    end
    inflight_d = ren;
  end

  always_comb begin
    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    occ_d    = occ_q;
    unique case ({pop, inflight_q})
      2'b10: begin
        buf_d[0] = buf_q[1];
        occ_d    = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) buf_d[0] = mem_rdata;
        else               buf_d[1] = mem_rdata;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf_d[0] = mem_rdata;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      rd_ptr_bin_q  <= '0;
      rd_ptr_gray_q <= '0;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
      occ_q         <= 2'd0;
      inflight_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      rd_ptr_bin_q  <= rd_ptr_bin_d;
      rd_ptr_gray_q <= rd_ptr_gray_d;
      buf_q[0]      <= buf_d[0];
      buf_q[1]      <= buf_d[1];
      occ_q         <= occ_d;
      inflight_q    <= inflight_d;
    end
  end

  assign rd_ptr_gray = rd_ptr_gray_q;
  assign mem_ren     = ren;
  assign mem_raddr   = rd_ptr_bin_q[ADDR_WIDTH-1:0];
  assign dout        = buf_q[0];
  assign dout_valid  = (occ_q != 2'd0);
  assign empty       = ram_empty & !inflight_q & (occ_q == 2'd0);
  assign rd_level    = wq_ptr_bin - rd_ptr_bin_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl with a registered-read RAM model and a
// software write pointer standing in for the write domain.
module tb_async_fifo_rd_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] wr_ptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       mem_ren;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       empty;
  logic [4:0] rd_level;

  logic [7:0] mem [16];
  logic [4:0] wr_bin;
  int         total;
  int         bad;

  async_fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .empty      (empty),
    .rd_level   (rd_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_raddr];
  end

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_bin[3:0]] = d;
    wr_bin      = wr_bin + 5'd1;
    wr_ptr_gray = gray5(wr_bin);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         nren;
    int         popped;
    int         writes;
    logic       wrap_seen;
    logic [4:0] prev_gray;

    clk         = 1'b0;
    rst         = 1'b1;
    wr_ptr_gray = 5'b00011;
    dout_ready  = 1'b0;
    wr_bin      = 5'd0;
    mem_rdata   = 8'h00;
    total       = 0;
    bad         = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // reset held for three cycles with a non-zero incoming pointer
    repeat (3) begin
      step();
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ren", mem_ren, 0);
      chk("rst_empty", empty, 1);
      chk("rst_rdgray", rd_ptr_gray, 0);
      chk("rst_level", rd_level, 0);
    end
    wr_ptr_gray = 5'b00000;
    rst         = 1'b0;
    step();
    chk("rst_no_ren", mem_ren, 0);
    chk("rst_empty_after", empty, 1);

    // single word
    push(8'hA5);
    dout_ready = 1'b1;
    step();
    chk("single_ren_early", mem_ren, 0);
    step();
    chk("single_ren", mem_ren, 1);
    chk("single_level", rd_level, 1);
    step();
    chk("single_ren_off", mem_ren, 0);
    chk("single_valid_early", dout_valid, 0);
    chk("single_rdgray_adv", rd_ptr_gray, 5'b00001);
    chk("single_not_empty", empty, 0);
    step();
    chk("single_valid", dout_valid, 1);
    chk("single_dout", dout, 8'hA5);
    step();
    chk("single_empty", empty, 1);
    chk("single_valid_off", dout_valid, 0);
    chk("single_rdgray", rd_ptr_gray, 5'b00001);

    // streaming a full RAM
    rst         = 1'b1;
    wr_bin      = 5'd0;
    wr_ptr_gray = 5'd0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("stream_wgray", wr_ptr_gray, 5'b11000);
    step();
    step();
    chk("stream_level_full", rd_level, 16);
    chk("stream_ren", mem_ren, 1);
    chk("stream_not_empty", empty, 0);
    n = 0;
    while (!dout_valid && n < 10) begin
      step();
      n++;
    end
    chk("stream_start", dout_valid, 1);
    for (int k = 0; k < 16; k++) begin
      chk("stream_valid", dout_valid, 1);
      chk("stream_data", dout, 32'(k));
      step();
    end
    chk("stream_valid_end", dout_valid, 0);
    chk("stream_level_end", rd_level, 0);
    chk("stream_rdgray_end", rd_ptr_gray, 5'b11000);
    chk("stream_empty_end", empty, 1);

    // backpressure
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    nren = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (mem_ren) nren++;
      if (dout_valid) chk("bp_hold", dout, 8'h40);
    end
    chk("bp_ren_count", nren, 2);
    chk("bp_valid", dout_valid, 1);
    chk("bp_dout", dout, 8'h40);
    chk("bp_level", rd_level, 2);
    dout_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_rel_valid", dout_valid, 1);
      chk("bp_rel_data", dout, 32'(8'h40 + k));
      step();
    end
    chk("bp_drained", dout_valid, 0);
    chk("bp_empty", empty, 1);

    // 40 words through the FIFO, crossing the pointer wrap
    popped    = 0;
    writes    = 0;
    wrap_seen = 1'b0;
    prev_gray = rd_ptr_gray;
    for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
      dout_ready = (cyc % 5 != 4);
      if (dout_valid && dout_ready) begin
        chk("wrap_data", dout, 32'(8'(8'h80 + popped)));
        popped++;
      end
      if (writes < 40 && (writes - popped) < 14) begin
        push(8'(8'h80 + writes));
        writes++;
      end
      step();
      chk("wrap_gray_step", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 1);
      if (prev_gray == 5'b10000 && rd_ptr_gray == 5'b00000) wrap_seen = 1'b1;
      prev_gray = rd_ptr_gray;
    end
    chk("wrap_popped", popped, 40);
    chk("wrap_seen", wrap_seen, 1);

    // reset with a read in flight
    step();
    step();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    n = 0;
    while (!dout_valid && n < 12) begin
      step();
      n++;
    end
    chk("mr_valid_pre", dout_valid, 1);
    rst         = 1'b1;
    wr_bin      = 5'd0;
    wr_ptr_gray = 5'd0;
    step();
    chk("mr_valid_rst", dout_valid, 0);
    chk("mr_ren_rst", mem_ren, 0);
    chk("mr_rdgray_rst", rd_ptr_gray, 0);
    chk("mr_empty_rst", empty, 1);
    rst = 1'b0;
    step();
    chk("mr_late_ignored", dout_valid, 0);
    step();
    chk("mr_still_empty", dout_valid, 0);
    push(8'hD5);
    dout_ready = 1'b1;
    n = 0;
    while (!dout_valid && n < 10) begin
      step();
      n++;
    end
    chk("mr_post_valid", dout_valid, 1);
    chk("mr_post_dout", dout, 8'hD5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
